// File: rtl/warp_fetcher.sv
// Two-slot instruction fetch unit: per-warp fetch slots sharing one program-memory read port.
// Optional WARP_FETCHER_PERF_EN adds saturating fetch/stall counters. Only NUM_WARPS=2 is supported.
module warp_fetcher #(
  parameter int PROGRAM_ADDR_BITS = 8,
  parameter int PROGRAM_DATA_BITS = 16,
  parameter int NUM_WARPS         = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   core_state,
  input  logic                         warp_select,
  input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                   fetcher_state,
  output logic [PROGRAM_DATA_BITS-1:0] instruction
`ifdef WARP_FETCHER_PERF_EN
  ,
  output logic [15:0]                  fetch_count,
  output logic [15:0]                  stall_cycles
`endif
);

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_PENDING,
    SLOT_BUSY,
    SLOT_FETCHED
  } slot_state_e;

  slot_state_e                  r_state [NUM_WARPS];
  logic [PROGRAM_ADDR_BITS-1:0] r_tag   [NUM_WARPS];
  logic [PROGRAM_DATA_BITS-1:0] r_instr [NUM_WARPS];
  logic                         r_valid;
  logic [PROGRAM_ADDR_BITS-1:0] r_addr;
  logic                         r_busy_slot;
  logic                         r_rr;

  logic                         w_new_req [NUM_WARPS];
  logic                         w_req     [NUM_WARPS];
  logic                         w_grant   [NUM_WARPS];
  logic                         w_grant_any;
  logic                         w_grant_slot;
  logic [PROGRAM_ADDR_BITS-1:0] w_grant_addr;
  logic                         w_done;

  function automatic logic [2:0] state_code(input slot_state_e s);
    case (s)
      SLOT_PENDING, SLOT_BUSY: state_code = 3'b001;
      SLOT_FETCHED:            state_code = 3'b010;
      default:                 state_code = 3'b000;
    endcase
  endfunction

  assign w_done = r_valid && mem_read_ready;

  // A slot that requests this cycle competes immediately, so a free port
  // costs no extra cycle between FETCH and the memory request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_new_req[i] = 1'b0;
      w_req[i]     = 1'b0;
      w_grant[i]   = 1'b0;
    end
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_new_req[i] = (warp_select == 1'(i)) && (core_state == CORE_FETCH) &&
                     ((r_state[i] == SLOT_IDLE) ||
                      ((r_state[i] == SLOT_FETCHED) && (current_pc != r_tag[i])));
      w_req[i]     = (r_state[i] == SLOT_PENDING) || w_new_req[i];
    end
    w_grant_any  = !r_valid && (w_req[0] || w_req[1]);
    w_grant_slot = (w_req[0] && w_req[1]) ? r_rr : w_req[1];
    w_grant_addr = w_new_req[w_grant_slot] ? current_pc : r_tag[w_grant_slot];
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_grant[i] = w_grant_any && (w_grant_slot == 1'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: slot storage is a handful of flops, so it is reset outright rather than treated as RAM.
      for (int i = 0; i < NUM_WARPS; i++) begin
        r_state[i] <= SLOT_IDLE;
        r_tag[i]   <= '0;
        r_instr[i] <= '0;
      end
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_busy_slot <= 1'b0;
      r_rr        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every slot update based on this cycle's state.
      for (int i = 0; i < NUM_WARPS; i++) begin
        case (r_state[i])
          SLOT_IDLE: begin
            if (w_new_req[i]) begin
              r_tag[i]   <= current_pc;
              r_state[i] <= w_grant[i] ? SLOT_BUSY : SLOT_PENDING;
            end
          end
          SLOT_PENDING: begin
            if (w_grant[i]) r_state[i] <= SLOT_BUSY;
          end
          SLOT_BUSY: begin
            if (w_done && (r_busy_slot == 1'(i))) begin
              r_instr[i] <= mem_read_data;
              r_state[i] <= SLOT_FETCHED;
            end
          end
          SLOT_FETCHED: begin
            if (w_new_req[i]) begin
              r_tag[i]   <= current_pc;
              r_instr[i] <= '0;
              r_state[i] <= w_grant[i] ? SLOT_BUSY : SLOT_PENDING;
            end else if ((warp_select == 1'(i)) && (core_state == CORE_DECODE)) begin
              r_state[i] <= SLOT_IDLE;
            end
          end
          default: r_state[i] <= SLOT_IDLE;
        endcase
      end

      if (w_done) begin
        r_valid <= 1'b0;
      end else if (w_grant_any) begin
        r_valid     <= 1'b1;
        r_addr      <= w_grant_addr;
        r_busy_slot <= w_grant_slot;
        r_rr        <= ~w_grant_slot;
      end
    end
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = state_code(r_state[warp_select]);
  assign instruction      = r_instr[warp_select];

`ifdef WARP_FETCHER_PERF_EN
  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_done && (r_fetch_count != 16'hFFFF)) r_fetch_count <= r_fetch_count + 16'd1;
      if (r_valid && !mem_read_ready && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_warp_fetcher.sv
// Scoreboarded bench for warp_fetcher: stimulus queues expected request addresses,
// a memory-model monitor serves requests with a programmable stall and checks each handshake.
module tb_warp_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic        warp_select;
  logic [7:0]  current_pc;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
`ifdef WARP_FETCHER_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_cycles;
`endif

  localparam logic [2:0] C_IDLE = 3'b000, C_FETCH = 3'b001, C_DECODE = 3'b010;
  localparam logic [2:0] F_IDLE = 3'b000, F_FETCHING = 3'b001, F_FETCHED = 3'b010;

  int checks = 0;
  int errors = 0;
  int stall_cfg = 0;
  int wait_left = 0;
  logic [7:0] sb_q[$];

  warp_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .warp_select      (warp_select),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
`ifdef WARP_FETCHER_PERF_EN
    ,
    .fetch_count      (fetch_count),
    .stall_cycles     (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    case (a)
      8'h05:   mem_word = 16'h3A5C;
      8'h06:   mem_word = 16'hC0DE;
      8'h07:   mem_word = 16'h7E57;
      8'h10:   mem_word = 16'hBEEF;
      8'h20:   mem_word = 16'h1234;
      8'h30:   mem_word = 16'h3030;
      8'h32:   mem_word = 16'h3232;
      8'h33:   mem_word = 16'h3333;
      8'h40:   mem_word = 16'h4040;
      8'h41:   mem_word = 16'h4141;
      8'h42:   mem_word = 16'h4242;
      default: mem_word = 16'hDEAD;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] cs, input logic ws, input logic [7:0] pc);
    core_state  = cs;
    warp_select = ws;
    current_pc  = pc;
  endtask

  task automatic wait_state(input logic ws, input logic [2:0] exp, input string name);
    drive(C_IDLE, ws, current_pc);
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (fetcher_state == exp) break;
    end
    check(name, fetcher_state, exp);
  endtask

  task automatic decode(input logic ws);
    drive(C_DECODE, ws, current_pc);
    cyc();
    drive(C_IDLE, ws, current_pc);
  endtask

  task automatic set_stall(input int n);
    stall_cfg = n;
    cyc();
    cyc();
  endtask

  // Memory model and scoreboard monitor.
  initial begin
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_read_valid && !reset) begin
        if (wait_left > 0) begin
          mem_read_ready = 1'b0;
          wait_left--;
        end else begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_word(mem_read_address);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got address %0h expected no request", mem_read_address);
          end else begin
            check("req_addr", mem_read_address, sb_q.pop_front());
          end
        end
      end else begin
        mem_read_ready = 1'b0;
        wait_left      = stall_cfg;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(C_IDLE, 1'b0, 8'h00);
    cyc();
    cyc();
    check("rst_valid", mem_read_valid, 1'b0);
    check("rst_addr", mem_read_address, 8'h00);
    check("rst_fs0", fetcher_state, F_IDLE);
    warp_select = 1'b1;
    #1 check("rst_fs1", fetcher_state, F_IDLE);
    cyc();
    reset = 1'b0;
    set_stall(0);

    // Single fetch with ready tied high.
    sb_q.push_back(8'h05);
    drive(C_FETCH, 1'b0, 8'h05);
    cyc();
    check("single_valid", mem_read_valid, 1'b1);
    check("single_addr", mem_read_address, 8'h05);
    check("single_fetching", fetcher_state, F_FETCHING);
    drive(C_IDLE, 1'b0, 8'h05);
    cyc();
    check("single_valid_drop", mem_read_valid, 1'b0);
    check("single_fetched", fetcher_state, F_FETCHED);
    check("single_instr", instruction, 16'h3A5C);
    decode(1'b0);
    check("single_decode", fetcher_state, F_IDLE);
    check("single_retain", instruction, 16'h3A5C);

    // Stall on warp0, scheduler switches to warp1.
    set_stall(5);
    sb_q.push_back(8'h10);
    sb_q.push_back(8'h20);
    drive(C_FETCH, 1'b0, 8'h10);
    cyc();
    drive(C_FETCH, 1'b1, 8'h20);
    cyc();
    drive(C_IDLE, 1'b1, 8'h20);
    #1 check("stall_w1_waiting", fetcher_state, F_FETCHING);
    check("stall_addr_first", mem_read_address, 8'h10);
    wait_state(1'b0, F_FETCHED, "stall_w0_done");
    check("stall_w0_instr", instruction, 16'hBEEF);
    wait_state(1'b1, F_FETCHED, "stall_w1_done");
    check("stall_w1_instr", instruction, 16'h1234);
    warp_select = 1'b0;
    #1 check("stall_w0_hold", instruction, 16'hBEEF);
    decode(1'b0);
    decode(1'b1);

    // Round-robin occasion 1: slot0 wins the contest.
    set_stall(3);
    sb_q.push_back(8'h40);
    sb_q.push_back(8'h30);
    sb_q.push_back(8'h41);
    drive(C_FETCH, 1'b1, 8'h40);
    cyc();
    drive(C_FETCH, 1'b0, 8'h30);
    cyc();
    wait_state(1'b1, F_FETCHED, "rr1_w1_first");
    drive(C_FETCH, 1'b1, 8'h41);
    cyc();
    wait_state(1'b0, F_FETCHED, "rr1_w0_done");
    check("rr1_w0_instr", instruction, 16'h3030);
    wait_state(1'b1, F_FETCHED, "rr1_w1_done");
    check("rr1_w1_instr", instruction, 16'h4141);

    // Round-robin occasion 2: slot1 wins the contest.
    sb_q.push_back(8'h32);
    sb_q.push_back(8'h42);
    sb_q.push_back(8'h33);
    drive(C_FETCH, 1'b0, 8'h32);
    cyc();
    drive(C_FETCH, 1'b1, 8'h42);
    cyc();
    wait_state(1'b0, F_FETCHED, "rr2_w0_first");
    drive(C_FETCH, 1'b0, 8'h33);
    cyc();
    wait_state(1'b1, F_FETCHED, "rr2_w1_done");
    check("rr2_w1_instr", instruction, 16'h4242);
    wait_state(1'b0, F_FETCHED, "rr2_w0_done");
    check("rr2_w0_instr", instruction, 16'h3333);

    // Tag mismatch replaces the held instruction; a matching PC does not refetch.
    set_stall(0);
    sb_q.push_back(8'h05);
    drive(C_FETCH, 1'b0, 8'h05);
    cyc();
    wait_state(1'b0, F_FETCHED, "tag_first");
    check("tag_instr05", instruction, 16'h3A5C);
    sb_q.push_back(8'h06);
    drive(C_FETCH, 1'b0, 8'h06);
    cyc();
    check("tag_refetch", fetcher_state, F_FETCHING);
    check("tag_addr06", mem_read_address, 8'h06);
    wait_state(1'b0, F_FETCHED, "tag_second");
    check("tag_instr06", instruction, 16'hC0DE);
    drive(C_FETCH, 1'b0, 8'h06);
    cyc();
    drive(C_IDLE, 1'b0, 8'h06);
    check("tag_match_hold", fetcher_state, F_FETCHED);
    check("tag_match_noreq", mem_read_valid, 1'b0);

    // Reset in the middle of a stalled request.
    set_stall(50);
    drive(C_FETCH, 1'b1, 8'h07);
    cyc();
    drive(C_IDLE, 1'b1, 8'h07);
    cyc();
    check("midrst_busy", mem_read_valid, 1'b1);
    #1 reset = 1'b1;
    #1 check("midrst_valid", mem_read_valid, 1'b0);
    check("midrst_addr", mem_read_address, 8'h00);
    check("midrst_fs1", fetcher_state, F_IDLE);
    warp_select = 1'b0;
    #1 check("midrst_fs0", fetcher_state, F_IDLE);
    check("midrst_instr", instruction, 16'h0000);
    cyc();
    reset = 1'b0;

    // Three fetches, each with two not-ready cycles.
    set_stall(2);
    sb_q.push_back(8'h05);
    drive(C_FETCH, 1'b0, 8'h05);
    cyc();
    wait_state(1'b0, F_FETCHED, "perf_f1");
    check("perf_i1", instruction, 16'h3A5C);
    sb_q.push_back(8'h06);
    drive(C_FETCH, 1'b0, 8'h06);
    cyc();
    wait_state(1'b0, F_FETCHED, "perf_f2");
    check("perf_i2", instruction, 16'hC0DE);
    sb_q.push_back(8'h07);
    drive(C_FETCH, 1'b0, 8'h07);
    cyc();
    wait_state(1'b0, F_FETCHED, "perf_f3");
    check("perf_i3", instruction, 16'h7E57);
`ifdef WARP_FETCHER_PERF_EN
    check("perf_fetch_count", fetch_count, 16'd3);
    check("perf_stall_cycles", stall_cycles, 16'd6);
`endif

    cyc();
    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
